imem_responder: RTL and testbench
=================================

IMEM_RESPONDER -- requirements
Module: imem_responder

Interface
REQ-001 The block SHALL have parameter DEPTH_LOG2, default 8, giving log2 of the memory word count (256 words).
REQ-002 The block SHALL have parameter LATENCY, default 2, legal range 1..15, giving the cycles from request acceptance to ok.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 read_req  input  1  instruction fetch request from the cache; held high until ok is seen.
REQ-006 addr  input  32  byte address of the fetch, valid while read_req is high.
REQ-007 ok  output  1  one-cycle response strobe.
REQ-008 data  output  32  fetched word, valid only while ok is high, else 0.
REQ-009 wr_en  input  1  preload write enable (testbench/loader port).
REQ-010 wr_addr  input  32  preload byte address.
REQ-011 wr_data  input  32  preload word.
REQ-012 err  output  1  out-of-range flag; present only when IMEM_ERR_EN is defined (see Configuration).

Function
REQ-013 Storage SHALL be 2^DEPTH_LOG2 32-bit words, indexed by address bits [DEPTH_LOG2+1:2]; bits [1:0] are ignored.
REQ-014 FSM states SHALL be IDLE, WAIT, RESP.
REQ-015 IDLE: on an edge with read_req=1, the block SHALL capture the word index from addr, load a 4-bit down-counter with LATENCY-1, and go to WAIT (or to RESP if LATENCY=1).
REQ-016 WAIT: the counter SHALL decrement each cycle; on the edge where it reads 1, the block SHALL go to RESP.
REQ-017 On the edge entering RESP, the block SHALL register mem[captured index] into the data register using the pre-edge memory contents.
REQ-018 RESP: ok=1 and data=registered word for exactly one cycle, then unconditionally IDLE.
REQ-019 Latency: ok SHALL be high in the cycle that begins LATENCY edges after the accepting edge.
REQ-020 Changes to addr after acceptance SHALL be ignored until the next IDLE acceptance.
REQ-021 If read_req is low on any edge in WAIT, the block SHALL abort to IDLE without asserting ok.
REQ-022 read_req high in the first IDLE cycle after RESP SHALL be accepted as a new request; no dead cycle is inserted.
REQ-023 wr_en=1 SHALL write wr_data to mem[wr_addr index] on the edge, in any state; the write is not blocked by reads.
REQ-024 A write to the captured index before the RESP-entry edge SHALL be visible in data; a write on that same edge SHALL NOT be visible (old value returned).
REQ-025 Outside RESP, ok=0 and data=0.

Reset
REQ-026 rst_n low SHALL immediately force state IDLE, counter 0, data register 0, ok=0, data=0, err=0, independent of clk.
REQ-027 Reset mid-WAIT or mid-RESP SHALL drop the pending request with no ok after release.
REQ-028 Memory contents SHALL NOT be cleared by reset.

Configuration
REQ-029 Macro IMEM_ERR_EN SHALL control out-of-range checking.
REQ-030 With IMEM_ERR_EN defined: port err exists; a request whose addr[31:DEPTH_LOG2+2] is nonzero SHALL complete with normal latency, ok=1, err=1, data=0; err=0 in all other cycles. Out-of-range writes SHALL be dropped.
REQ-031 Without IMEM_ERR_EN: no err port; high address bits SHALL be ignored, so addresses wrap modulo the memory size for both reads and writes.

Verification
REQ-032 Preload mem[0x10]=0xDEADBEEF via wr_addr=0x40; read_req=1, addr=0x40, LATENCY=2 -> ok=1, data=0xDEADBEEF exactly 2 cycles after acceptance, for 1 cycle.
REQ-033 LATENCY=1, back-to-back requests at addr 0x0 then 0x4, read_req held high -> ok in consecutive-response pattern: ok, IDLE accept, ok; no cycle lost beyond RESP->IDLE.
REQ-034 Accept request at addr 0x80, drop read_req in WAIT (LATENCY=4) -> no ok ever; next request at 0x84 returns mem[0x21] normally.
REQ-035 Write 0x12345678 to addr 0x80 during WAIT of a read of 0x80 -> data=0x12345678; write on the RESP-entry edge -> old value returned.
REQ-036 Assert rst_n low during WAIT -> ok, data stay 0 after release; preloaded mem[0x10] still reads 0xDEADBEEF.
REQ-037 IMEM_ERR_EN defined, DEPTH_LOG2=8, addr=0x400 -> ok=1, err=1, data=0; undefined, addr=0x440 -> data=mem[0x10].

Source files
------------

// File: rtl/imem_if.sv
// Fetch request/response and preload write bundle between an instruction cache/loader
// and imem_responder. The err wire exists only when IMEM_ERR_EN is defined.
interface imem_if;
  logic        read_req;
  logic [31:0] addr;
  logic        ok;
  logic [31:0] data;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
`ifdef IMEM_ERR_EN
  logic        err;

  modport master (output read_req, addr, wr_en, wr_addr, wr_data,
                  input  ok, data, err);
  modport slave  (input  read_req, addr, wr_en, wr_addr, wr_data,
                  output ok, data, err);
`else
  modport master (output read_req, addr, wr_en, wr_addr, wr_data,
                  input  ok, data);
  modport slave  (input  read_req, addr, wr_en, wr_addr, wr_data,
                  output ok, data);
`endif
endinterface

// File: rtl/imem_responder.sv
// Instruction memory with fixed-latency fetch response and a preload write port.
// Define IMEM_ERR_EN to enable out-of-range flagging (err port, dropped writes).
module imem_responder #(
  parameter int DEPTH_LOG2 = 8,
  parameter int LATENCY    = 2
) (
  input  logic   clk,
  input  logic   rst_n,
  imem_if.slave  bus
);
  localparam int         DEPTH    = 1 << DEPTH_LOG2;
  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef struct packed {
    logic [DEPTH_LOG2-1:0] idx;
`ifdef IMEM_ERR_EN
    logic                  oor;
`endif
  } req_t;

  logic [31:0] mem [DEPTH];

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  req_t        req_q, req_d;
  req_t        req_in;
  logic [31:0] data_q, data_d;
  logic [DEPTH_LOG2-1:0] rd_idx;
  logic [31:0] rd_word;
  logic        rd_oor;
  logic        wr_ok;
  logic        unused_addr_bits;
`ifdef IMEM_ERR_EN
  logic        err_q, err_d;
`endif

  // Request as seen on the bus this cycle; only latched on an IDLE acceptance.
  always_comb begin
    req_in     = '0;
    req_in.idx = bus.addr[DEPTH_LOG2+1:2];
`ifdef IMEM_ERR_EN
    req_in.oor = |bus.addr[31:DEPTH_LOG2+2];
`endif
  end

`ifdef IMEM_ERR_EN
  assign wr_ok            = bus.wr_en & ~(|bus.wr_addr[31:DEPTH_LOG2+2]);
  assign unused_addr_bits = ^{bus.addr[1:0], bus.wr_addr[1:0]};
`else
  assign wr_ok            = bus.wr_en;
  assign unused_addr_bits = ^{bus.addr[31:DEPTH_LOG2+2], bus.addr[1:0],
                              bus.wr_addr[31:DEPTH_LOG2+2], bus.wr_addr[1:0]};
`endif

  // Not reset: preloaded program must survive a core reset.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[bus.wr_addr[DEPTH_LOG2+1:2]] <= bus.wr_data;
  end

  // With LATENCY=1 the word is read on the accepting edge, so the index comes
  // straight from the bus rather than from the captured request.
  always_comb begin
    rd_idx  = (state_q == IDLE) ? req_in.idx : req_q.idx;
    rd_word = mem[rd_idx];
`ifdef IMEM_ERR_EN
    rd_oor  = (state_q == IDLE) ? req_in.oor : req_q.oor;
`else
    rd_oor  = 1'b0;
`endif
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    data_d  = '0;
`ifdef IMEM_ERR_EN
    err_d   = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (bus.read_req) begin
          req_d = req_in;
          if (LATENCY == 1) begin
            state_d = RESP;
            data_d  = rd_oor ? 32'h0 : rd_word;
`ifdef IMEM_ERR_EN
            err_d   = rd_oor;
`endif
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_LOAD;
          end
        end
      end
      WAIT: begin
        if (!bus.read_req) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_d = RESP;
            data_d  = rd_oor ? 32'h0 : rd_word;
`ifdef IMEM_ERR_EN
            err_d   = rd_oor;
`endif
          end
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      req_q   <= '0;
      data_q  <= '0;
`ifdef IMEM_ERR_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      data_q  <= data_d;
`ifdef IMEM_ERR_EN
      err_q   <= err_d;
`endif
    end
  end

  // data_q/err_q are only nonzero while in RESP; the state gate keeps the
  // outputs clean even so.
  assign bus.ok   = (state_q == RESP);
  assign bus.data = (state_q == RESP) ? data_q : 32'h0;
`ifdef IMEM_ERR_EN
  assign bus.err  = (state_q == RESP) & err_q;
`endif

endmodule

// File: tb/tb_imem_responder.sv
// Directed bench: three responders (LATENCY 2, 1, 4) share clock, reset and the
// preload write port; fetch requests are driven per instance.
module tb_imem_responder;
  logic        clk;
  logic        rst_n;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  int          checks;
  int          errors;

  imem_if if2 ();
  imem_if if1 ();
  imem_if if4 ();

  assign if2.wr_en = wr_en;  assign if2.wr_addr = wr_addr;  assign if2.wr_data = wr_data;
  assign if1.wr_en = wr_en;  assign if1.wr_addr = wr_addr;  assign if1.wr_data = wr_data;
  assign if4.wr_en = wr_en;  assign if4.wr_addr = wr_addr;  assign if4.wr_data = wr_data;

  imem_responder #(.DEPTH_LOG2(8), .LATENCY(2)) u_dut2 (.clk(clk), .rst_n(rst_n), .bus(if2.slave));
  imem_responder #(.DEPTH_LOG2(8), .LATENCY(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));
  imem_responder #(.DEPTH_LOG2(8), .LATENCY(4)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(if4.slave));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    step();
    wr_en = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    checks++; if (if2.ok !== 1'b0 || if2.data !== 32'h0) begin errors++; $display("FAIL reset_d2 ok=%b data=%h exp 0/0", if2.ok, if2.data); end
    checks++; if (if1.ok !== 1'b0 || if1.data !== 32'h0) begin errors++; $display("FAIL reset_d1 ok=%b data=%h exp 0/0", if1.ok, if1.data); end
    checks++; if (if4.ok !== 1'b0 || if4.data !== 32'h0) begin errors++; $display("FAIL reset_d4 ok=%b data=%h exp 0/0", if4.ok, if4.data); end
`ifdef IMEM_ERR_EN
    checks++; if (if2.err !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", if2.err); end
`endif
    step(); step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic preload();
    wr(32'h40, 32'hDEADBEEF);
    wr(32'h80, 32'hA0A0A0A0);
    wr(32'h84, 32'h21212121);
    wr(32'h00, 32'h11110000);
    wr(32'h04, 32'h22220004);
  endtask

  task automatic test_basic();
    if2.read_req = 1'b1; if2.addr = 32'h40;
    step();
    checks++; if (if2.ok !== 1'b0) begin errors++; $display("FAIL basic_wait_ok got %b exp 0", if2.ok); end
    if2.addr = 32'h80;
    step();
    checks++; if (if2.ok !== 1'b1 || if2.data !== 32'hDEADBEEF) begin errors++; $display("FAIL basic_resp ok=%b data=%h exp 1/deadbeef", if2.ok, if2.data); end
    if2.read_req = 1'b0;
    step();
    checks++; if (if2.ok !== 1'b0 || if2.data !== 32'h0) begin errors++; $display("FAIL basic_after ok=%b data=%h exp 0/0", if2.ok, if2.data); end
  endtask

  task automatic test_back_to_back();
    if1.read_req = 1'b1; if1.addr = 32'h0;
    step();
    checks++; if (if1.ok !== 1'b1 || if1.data !== 32'h11110000) begin errors++; $display("FAIL b2b_first ok=%b data=%h exp 1/11110000", if1.ok, if1.data); end
    if1.addr = 32'h4;
    step();
    checks++; if (if1.ok !== 1'b0 || if1.data !== 32'h0) begin errors++; $display("FAIL b2b_idle ok=%b data=%h exp 0/0", if1.ok, if1.data); end
    step();
    checks++; if (if1.ok !== 1'b1 || if1.data !== 32'h22220004) begin errors++; $display("FAIL b2b_second ok=%b data=%h exp 1/22220004", if1.ok, if1.data); end
    if1.read_req = 1'b0;
    step();
    checks++; if (if1.ok !== 1'b0) begin errors++; $display("FAIL b2b_end ok=%b exp 0", if1.ok); end
  endtask

  task automatic test_abort();
    int oks;
    if4.read_req = 1'b1; if4.addr = 32'h80;
    step(); step();
    if4.read_req = 1'b0;
    oks = 0;
    for (int i = 0; i < 9; i++) begin
      step();
      if (if4.ok === 1'b1) oks++;
    end
    checks++; if (oks !== 0) begin errors++; $display("FAIL abort_no_ok got %0d ok cycles exp 0", oks); end
    if4.read_req = 1'b1; if4.addr = 32'h84;
    oks = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (if4.ok === 1'b1) oks++;
    end
    checks++; if (oks !== 0) begin errors++; $display("FAIL abort_early_ok got %0d exp 0", oks); end
    step();
    checks++; if (if4.ok !== 1'b1 || if4.data !== 32'h21212121) begin errors++; $display("FAIL abort_next ok=%b data=%h exp 1/21212121", if4.ok, if4.data); end
    if4.read_req = 1'b0;
    step();
  endtask

  task automatic test_write_hazard();
    if4.read_req = 1'b1; if4.addr = 32'h80;
    step();
    wr_en = 1'b1; wr_addr = 32'h80; wr_data = 32'h12345678;
    step();
    wr_en = 1'b0;
    step(); step();
    checks++; if (if4.ok !== 1'b1 || if4.data !== 32'h12345678) begin errors++; $display("FAIL wr_in_wait ok=%b data=%h exp 1/12345678", if4.ok, if4.data); end
    if4.read_req = 1'b0;
    step();
    if4.read_req = 1'b1; if4.addr = 32'h80;
    step(); step(); step();
    wr_en = 1'b1; wr_addr = 32'h80; wr_data = 32'h55555555;
    step();
    wr_en = 1'b0;
    checks++; if (if4.ok !== 1'b1 || if4.data !== 32'h12345678) begin errors++; $display("FAIL wr_same_edge ok=%b data=%h exp 1/12345678", if4.ok, if4.data); end
    if4.read_req = 1'b0;
    step();
    if1.read_req = 1'b1; if1.addr = 32'h80;
    step();
    checks++; if (if1.ok !== 1'b1 || if1.data !== 32'h55555555) begin errors++; $display("FAIL wr_landed ok=%b data=%h exp 1/55555555", if1.ok, if1.data); end
    if1.read_req = 1'b0;
    step();
  endtask

  task automatic test_reset_mid();
    int oks;
    if2.read_req = 1'b1; if2.addr = 32'h40;
    step(); step();
    checks++; if (if2.ok !== 1'b1) begin errors++; $display("FAIL rst_pre_resp ok=%b exp 1", if2.ok); end
    #1 rst_n = 1'b0;
    #1;
    checks++; if (if2.ok !== 1'b0 || if2.data !== 32'h0) begin errors++; $display("FAIL rst_async ok=%b data=%h exp 0/0", if2.ok, if2.data); end
    if2.read_req = 1'b0;
    step();
    rst_n = 1'b1;
    oks = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (if2.ok === 1'b1 || if2.data !== 32'h0) oks++;
    end
    checks++; if (oks !== 0) begin errors++; $display("FAIL rst_resp_drop got %0d active cycles exp 0", oks); end
    if4.read_req = 1'b1; if4.addr = 32'h40;
    step(); step();
    rst_n = 1'b0;
    if4.read_req = 1'b0;
    step();
    rst_n = 1'b1;
    oks = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (if4.ok === 1'b1 || if4.data !== 32'h0) oks++;
    end
    checks++; if (oks !== 0) begin errors++; $display("FAIL rst_wait_drop got %0d active cycles exp 0", oks); end
    if2.read_req = 1'b1; if2.addr = 32'h40;
    step(); step();
    checks++; if (if2.ok !== 1'b1 || if2.data !== 32'hDEADBEEF) begin errors++; $display("FAIL rst_mem_kept ok=%b data=%h exp 1/deadbeef", if2.ok, if2.data); end
    if2.read_req = 1'b0;
    step();
  endtask

  task automatic test_range();
`ifdef IMEM_ERR_EN
    if2.read_req = 1'b1; if2.addr = 32'h400;
    step();
    checks++; if (if2.ok !== 1'b0 || if2.err !== 1'b0) begin errors++; $display("FAIL oor_wait ok=%b err=%b exp 0/0", if2.ok, if2.err); end
    step();
    checks++; if (if2.ok !== 1'b1 || if2.err !== 1'b1 || if2.data !== 32'h0) begin errors++; $display("FAIL oor_resp ok=%b err=%b data=%h exp 1/1/0", if2.ok, if2.err, if2.data); end
    if2.read_req = 1'b0;
    step();
    checks++; if (if2.err !== 1'b0) begin errors++; $display("FAIL oor_after err=%b exp 0", if2.err); end
    wr(32'h440, 32'h99999999);
    if2.read_req = 1'b1; if2.addr = 32'h40;
    step(); step();
    checks++; if (if2.ok !== 1'b1 || if2.err !== 1'b0 || if2.data !== 32'hDEADBEEF) begin errors++; $display("FAIL oor_wr_drop ok=%b err=%b data=%h exp 1/0/deadbeef", if2.ok, if2.err, if2.data); end
    if2.read_req = 1'b0;
    step();
`else
    if2.read_req = 1'b1; if2.addr = 32'h440;
    step(); step();
    checks++; if (if2.ok !== 1'b1 || if2.data !== 32'hDEADBEEF) begin errors++; $display("FAIL wrap_rd ok=%b data=%h exp 1/deadbeef", if2.ok, if2.data); end
    if2.read_req = 1'b0;
    step();
    wr(32'h444, 32'h77777777);
    if2.read_req = 1'b1; if2.addr = 32'h44;
    step(); step();
    checks++; if (if2.ok !== 1'b1 || if2.data !== 32'h77777777) begin errors++; $display("FAIL wrap_wr ok=%b data=%h exp 1/77777777", if2.ok, if2.data); end
    if2.read_req = 1'b0;
    step();
`endif
  endtask

  initial begin
    checks = 0; errors = 0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    if2.read_req = 1'b0; if2.addr = '0;
    if1.read_req = 1'b0; if1.addr = '0;
    if4.read_req = 1'b0; if4.addr = '0;
    test_reset();
    preload();
    test_basic();
    test_back_to_back();
    test_abort();
    test_write_hazard();
    test_reset_mid();
    test_range();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
